// File: rtl/raifes_qspi_sram_ctrl.sv
// Quad-SPI (SQI) serial SRAM sequencer: one 1/2/4-byte read or write per request.
// Define RAIFES_QSPI_INIT_EN to send RSTQIO + EQIO after reset before accepting requests.
module raifes_qspi_sram_ctrl #(
    parameter logic [7:0] CMD_READ      = 8'h03,
    parameter logic [7:0] CMD_WRITE     = 8'h02,
    parameter int         DUMMY_NIBBLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    input  logic [3:0]  io_in,
    output logic [3:0]  io_out,
    output logic [3:0]  io_en,
    output logic        sck,
    output logic        ncs,
    output logic        nhsb
);
    typedef enum logic [2:0] {
        INIT_RST, INIT_EQIO, IDLE, CMD, ADDR, DUMMY, DATA, END
    } state_t;

    localparam logic [7:0] EQIO_CMD   = 8'h38;
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);

    state_t      state_q, state_d, nxt_state;
    logic        phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d, last_cnt, data_last;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  cmd;
    logic [4:0]  pos;

    // Data nibble c sits in byte c/2, high nibble on even c.
    assign pos       = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    assign cmd       = write_q ? CMD_WRITE : CMD_READ;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign nhsb      = 1'b1;

    always_comb begin
        case (size_q)
            2'd0:    data_last = 4'd1;
            2'd1:    data_last = 4'd3;
            default: data_last = 4'd7;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        nxt_state   = IDLE;
        last_cnt    = 4'd0;
        ncs         = 1'b1;
        sck         = 1'b0;
        io_out      = 4'h0;
        io_en       = 4'h0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = CMD;
                    phase_d = 1'b0;
                    cnt_d   = 4'd0;
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rbuf_d  = 32'h0;
                end
            end
            CMD: begin
                ncs       = 1'b0;
                sck       = phase_q;
                io_en     = 4'hF;
                io_out    = cnt_q[0] ? cmd[3:0] : cmd[7:4];
                last_cnt  = 4'd1;
                nxt_state = ADDR;
            end
            ADDR: begin
                ncs   = 1'b0;
                sck   = phase_q;
                io_en = 4'hF;
                case (cnt_q)
                    4'd0:    io_out = addr_q[23:20];
                    4'd1:    io_out = addr_q[19:16];
                    4'd2:    io_out = addr_q[15:12];
                    4'd3:    io_out = addr_q[11:8];
                    4'd4:    io_out = addr_q[7:4];
                    default: io_out = addr_q[3:0];
                endcase
                last_cnt  = 4'd5;
                nxt_state = (write_q || DUMMY_NIBBLES == 0) ? DATA : DUMMY;
            end
            DUMMY: begin
                ncs       = 1'b0;
                sck       = phase_q;
                last_cnt  = DUMMY_LAST;
                nxt_state = DATA;
            end
            DATA: begin
                ncs       = 1'b0;
                sck       = phase_q;
                last_cnt  = data_last;
                nxt_state = END;
                if (write_q) begin
                    io_en  = 4'hF;
                    io_out = wdata_q[pos +: 4];
                end else if (phase_q) begin
                    rbuf_d[pos +: 4] = io_in;
                end
                if (phase_q && cnt_q == data_last) begin
                    rsp_valid_d = 1'b1;
                    if (!write_q) rsp_rdata_d = rbuf_d;
                end
            end
            END: begin
                last_cnt  = 4'd0;
                nxt_state = IDLE;
            end
`ifdef RAIFES_QSPI_INIT_EN
            // Slot 0 and 3 deselect; slots 1-2 carry RSTQIO as two quad nibbles.
            INIT_RST: begin
                if (cnt_q == 4'd1 || cnt_q == 4'd2) begin
                    ncs    = 1'b0;
                    sck    = phase_q;
                    io_en  = 4'hF;
                    io_out = 4'hF;
                end
                last_cnt  = 4'd3;
                nxt_state = INIT_EQIO;
            end
            // Slots 0-7 shift EQIO out on IO0; slot 8 is the trailing deselect.
            INIT_EQIO: begin
                if (cnt_q < 4'd8) begin
                    ncs    = 1'b0;
                    sck    = phase_q;
                    io_en  = 4'b0001;
                    io_out = {3'b000, EQIO_CMD[3'd7 - cnt_q[2:0]]};
                end
                last_cnt  = 4'd8;
                nxt_state = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                if (cnt_q == last_cnt) begin
                    state_d = nxt_state;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef RAIFES_QSPI_INIT_EN
            state_q <= INIT_RST;
`else
            state_q <= IDLE;
`endif
            phase_q     <= 1'b0;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= 24'h0;
            wdata_q     <= 32'h0;
            rbuf_q      <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_raifes_qspi_sram_ctrl.sv
// Directed bench for raifes_qspi_sram_ctrl with a pin-level SQI SRAM read model.
module tb_raifes_qspi_sram_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  io_in;
  logic [3:0]  io_out;
  logic [3:0]  io_en;
  logic        sck;
  logic        ncs;
  logic        nhsb;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mon_q[$];
  logic [3:0] exp_q[$];
  logic [7:0] sram_b[4];
  int         mdl_cnt = 0;
  int         mdl_d;
  logic [7:0] mdl_byte;

  raifes_qspi_sram_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .io_in(io_in), .io_out(io_out), .io_en(io_en),
    .sck(sck), .ncs(ncs), .nhsb(nhsb)
  );

  // clock / reset
  always #5 clk = ~clk;

  // SRAM read model: counts completed sck-high periods within a frame;
  // after 8 command/address nibbles and 2 dummies it presents data nibbles.
  always @(posedge clk) begin
    if (ncs) mdl_cnt <= 0;
    else if (sck) mdl_cnt <= mdl_cnt + 1;
  end

  always_comb begin
    mdl_d = mdl_cnt - 10;
    mdl_byte = 8'h00;
    io_in = 4'h0;
    if (mdl_d >= 0 && mdl_d < 8) begin
      mdl_byte = sram_b[mdl_d / 2];
      io_in = (mdl_d % 2 == 0) ? mdl_byte[7:4] : mdl_byte[3:0];
    end
  end

  // pin monitor: one entry per sck-high phase while selected
  always @(negedge clk) begin
    if (!ncs && sck) mon_q.push_back({io_en, io_out});
  end

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame check: n_tx driven nibbles (io_en=F) from the top of nibs, then n_rx undriven.
  task automatic check_frame(input string tag, input logic [63:0] nibs, input int n_tx, input int n_rx);
    logic [7:0] e;
    logic [3:0] x;
    chk({tag, "_len"}, mon_q.size(), n_tx + n_rx);
    exp_q.delete();
    for (int i = 0; i < n_tx; i++) exp_q.push_back(nibs[63 - 4*i -: 4]);
    for (int i = 0; i < n_tx + n_rx && i < mon_q.size(); i++) begin
      e = mon_q[i];
      if (i < n_tx) begin
        x = exp_q.pop_front();
        chk($sformatf("%s_io%0d", tag, i), {28'h0, e[3:0]}, {28'h0, x});
        chk($sformatf("%s_en%0d", tag, i), {28'h0, e[7:4]}, 32'hF);
      end else begin
        chk($sformatf("%s_en%0d", tag, i), {28'h0, e[7:4]}, 32'h0);
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_req(input string tag, input logic w, input logic [23:0] a,
                           input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    mon_q.delete();
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    int first_rsp, rdy_k, bad, seen;
    sram_b[0] = 8'h00; sram_b[1] = 8'h00; sram_b[2] = 8'h00; sram_b[3] = 8'h00;
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_ncs", {31'h0, ncs}, 32'h1);
    chk("rst_sck", {31'h0, sck}, 32'h0);
    chk("rst_io_out", {28'h0, io_out}, 32'h0);
    chk("rst_io_en", {28'h0, io_en}, 32'h0);
    chk("rst_nhsb", {31'h0, nhsb}, 32'h1);
`ifdef RAIFES_QSPI_INIT_EN
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    mon_q.delete();
    rdy_k = 0;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        rdy_k = k;
        break;
      end
    end
    chk("init_ready_cycle", rdy_k, 27);
    chk("init_len", mon_q.size(), 10);
    if (mon_q.size() == 10) begin
      logic [7:0] eq;
      eq = 8'h38;
      for (int i = 0; i < 2; i++) chk($sformatf("init_rst%0d", i), {24'h0, mon_q[i]}, 32'hFF);
      for (int i = 0; i < 8; i++)
        chk($sformatf("init_eqio%0d", i), {24'h0, mon_q[2+i]}, {24'h0, 4'h1, 3'b000, eq[7-i]});
    end
`else
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
`endif

    // word write
    start_req("ww", 1'b1, 24'h000104, 2'd2, 32'hDEADBEEF);
    wait_rsp("ww", 33);
    check_frame("ww", 64'h02000104EFBEADDE, 16, 0);

    // word read
    sram_b[0] = 8'hEF; sram_b[1] = 8'hBE; sram_b[2] = 8'hAD; sram_b[3] = 8'hDE;
    start_req("wr", 1'b0, 24'h000104, 2'd2, 32'h0);
    wait_rsp("wr", 37);
    chk("wr_rdata", rsp_rdata, 32'hDEADBEEF);
    check_frame("wr", 64'h0300010400000000, 8, 10);

    // halfword read after a word of different value
    sram_b[0] = 8'h34; sram_b[1] = 8'h12; sram_b[2] = 8'hFF; sram_b[3] = 8'hFF;
    start_req("hr", 1'b0, 24'h000200, 2'd1, 32'h0);
    wait_rsp("hr", 29);
    chk("hr_rdata", rsp_rdata, 32'h00001234);

    // byte read
    sram_b[0] = 8'h5A; sram_b[1] = 8'h77; sram_b[2] = 8'h88; sram_b[3] = 8'h99;
    start_req("br", 1'b0, 24'h00FFFF, 2'd0, 32'h0);
    wait_rsp("br", 25);
    chk("br_rdata", rsp_rdata, 32'h0000005A);

    // byte write; read data must be held
    start_req("bw", 1'b1, 24'hABCDEF, 2'd0, 32'h123456A7);
    wait_rsp("bw", 21);
    check_frame("bw", 64'h02ABCDEFA7000000, 10, 0);
    chk("bw_rdata_hold", rsp_rdata, 32'h0000005A);

    // size 3 behaves as word
    sram_b[0] = 8'h11; sram_b[1] = 8'h22; sram_b[2] = 8'h33; sram_b[3] = 8'h44;
    start_req("s3", 1'b0, 24'h000010, 2'd3, 32'h0);
    wait_rsp("s3", 37);
    chk("s3_rdata", rsp_rdata, 32'h44332211);

    // back-to-back: req_valid held high across the first transaction
    @(negedge clk);
    mon_q.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h000020; req_size = 2'd2; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_addr = 24'h000040; req_wdata = 32'h0BADCAFE;
    first_rsp = -1; rdy_k = -1; bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rsp_valid && first_rsp < 0) first_rsp = k;
      if (req_ready && !ncs) bad++;
      if (req_ready) begin
        rdy_k = k;
        break;
      end
    end
    chk("b2b_first_lat", first_rsp, 33);
    chk("b2b_gap", rdy_k - first_rsp, 2);
    chk("b2b_ready_ncs", bad, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp("b2b_second", 33);

    // reset in the middle of a read
    sram_b[0] = 8'hA5; sram_b[1] = 8'hA5; sram_b[2] = 8'hA5; sram_b[3] = 8'hA5;
    start_req("rr", 1'b0, 24'h000300, 2'd2, 32'h0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_ncs", {31'h0, ncs}, 32'h1);
    chk("rr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rr_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rr_no_rsp", seen, 0);
    chk("rr_ready", {31'h0, req_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
